knn_topk_engine: RTL

KNN_TOPK_ENGINE -- requirements
Module: knn_topk_engine

---
 rtl/knn_topk_engine_pkg.sv | 18 +
 rtl/knn_topk_engine_sq_dist.sv | 64 ++++++
 rtl/knn_topk_engine.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/knn_topk_engine_pkg.sv
// Shared definitions for the k-nearest-neighbour top-K engine: controller
// state encoding and the squared-distance width derivation.
package knn_topk_engine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Two squared (COORD_W+1)-bit differences each fit in 2*COORD_W bits
    // unsigned, so their sum needs exactly one extra bit.
    function automatic int dist_w_f(input int coord_w);
        return 2 * coord_w + 1;
    endfunction

endpackage

// File: rtl/knn_topk_engine_sq_dist.sv
// Stage 1 of the engine: registered exact squared Euclidean distance between
// the latched test point and an incoming data point, with its label.
module knn_sq_dist
    import knn_topk_engine_pkg::*;
#(
    parameter  int COORD_W = 16,
    parameter  int LABEL_W = 8,
    localparam int DIST_W  = dist_w_f(COORD_W)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vld_p0,
    input  logic signed [COORD_W-1:0] test_x,
    input  logic signed [COORD_W-1:0] test_y,
    input  logic signed [COORD_W-1:0] in_x,
    input  logic signed [COORD_W-1:0] in_y,
    input  logic        [LABEL_W-1:0] label_p0,
    output logic                      vld_p1,
    output logic        [DIST_W-1:0]  dist_p1,
    output logic        [LABEL_W-1:0] label_p1
);

    // |d| <= 2^COORD_W - 1, so |d|^2 < 2^(2*COORD_W) and the product below
    // never loses significant bits at DIST_W.
    function automatic logic [DIST_W-1:0] sq_mag(input logic signed [COORD_W:0] d);
        logic [COORD_W:0] m;
        m = d[COORD_W] ? $unsigned(-d) : $unsigned(d);
        return DIST_W'(m) * DIST_W'(m);
    endfunction

    logic signed [COORD_W:0] dx, dy;
    logic                    vld_p1_d, vld_p1_q;
    logic [DIST_W-1:0]       dist_p1_d, dist_p1_q;
    logic [LABEL_W-1:0]      label_p1_d, label_p1_q;

    // Differences at COORD_W+1 bits are exact for any pair of inputs.
    always_comb begin
        dx         = {test_x[COORD_W-1], test_x} - {in_x[COORD_W-1], in_x};
        dy         = {test_y[COORD_W-1], test_y} - {in_y[COORD_W-1], in_y};
        vld_p1_d   = vld_p0;
        dist_p1_d  = sq_mag(dx) + sq_mag(dy);
        label_p1_d = label_p0;
    end

    // ---- stage 0 -> stage 1 boundary ----
    // Valid flag is the only stage-1 state that reset must clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_p1_q <= 1'b0;
        else      vld_p1_q <= vld_p1_d;
    end

    // Payload loads only with a real point; it is ignored while invalid.
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            dist_p1_q  <= dist_p1_d;
            label_p1_q <= label_p1_d;
        end
    end

    assign vld_p1   = vld_p1_q;
    assign dist_p1  = dist_p1_q;
    assign label_p1 = label_p1_q;

endmodule

// File: rtl/knn_topk_engine.sv
// Streaming top-K nearest-neighbour engine: computes squared distances from a
// latched test point and keeps the K closest points in a sorted list that
// accepts one new entry per cycle.
module knn_topk_engine
    import knn_topk_engine_pkg::*;
#(
    parameter  int COORD_W = 16,
    parameter  int K       = 4,
    parameter  int LABEL_W = 8,
    localparam int DIST_W  = dist_w_f(COORD_W)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic signed [COORD_W-1:0]   test_x,
    input  logic signed [COORD_W-1:0]   test_y,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [COORD_W-1:0]   in_x,
    input  logic signed [COORD_W-1:0]   in_y,
    input  logic        [LABEL_W-1:0]   in_label,
    input  logic                        in_last,
    output logic                        busy,
    output logic                        done,
    output logic        [K*DIST_W-1:0]  nbr_dist,
    output logic        [K*LABEL_W-1:0] nbr_label,
    output logic        [K-1:0]         nbr_valid
);

    state_e                    state_q, state_d;
    logic signed [COORD_W-1:0] test_x_q, test_x_d, test_y_q, test_y_d;
    logic                      xfer, start_acc;

    logic                      vld_p1;
    logic [DIST_W-1:0]         dist_p1;
    logic [LABEL_W-1:0]        label_p1;

    logic [DIST_W-1:0]         slot_dist_q [K];
    logic [DIST_W-1:0]         slot_dist_d [K];
    logic [LABEL_W-1:0]        slot_label_q[K];
    logic [LABEL_W-1:0]        slot_label_d[K];
    logic                      slot_vld_q  [K];
    logic                      slot_vld_d  [K];
    logic [DIST_W-1:0]         prev_dist   [K];
    logic [LABEL_W-1:0]        prev_label  [K];
    logic                      prev_vld    [K];
    logic [K-1:0]              gt, take_new, take_prev;

    assign in_ready  = (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign xfer      = in_valid && in_ready;
    assign start_acc = start && (state_q == IDLE);

    // Controller next state; the test point is captured only on an accepted start.
    always_comb begin
        state_d  = state_q;
        test_x_d = test_x_q;
        test_y_d = test_y_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    test_x_d = test_x;
                    test_y_d = test_y;
                end
            end
            RUN:     if (xfer && in_last) state_d = DRAIN;
            DRAIN:   if (!vld_p1) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    knn_sq_dist #(
        .COORD_W (COORD_W),
        .LABEL_W (LABEL_W)
    ) u_sq_dist (
        .clk      (clk),
        .rst      (rst),
        .vld_p0   (xfer),
        .test_x   (test_x_q),
        .test_y   (test_y_q),
        .in_x     (in_x),
        .in_y     (in_y),
        .label_p0 (in_label),
        .vld_p1   (vld_p1),
        .dist_p1  (dist_p1),
        .label_p1 (label_p1)
    );

    // Every slot compares against the stage-1 entry in parallel. Because the
    // list is sorted and filled from slot 0, gt is thermometer-coded: the
    // lowest set bit is the insertion point (strict > keeps ties in arrival
    // order), slots above it take their lower neighbour, and with no bit set
    // the list is left untouched.
    for (genvar i = 0; i < K; i++) begin : g_slot
        assign gt[i] = !slot_vld_q[i] || (slot_dist_q[i] > dist_p1);
        if (i == 0) begin : g_first
            assign take_new[i]   = gt[i];
            assign prev_dist[i]  = '0;
            assign prev_label[i] = '0;
            assign prev_vld[i]   = 1'b0;
        end else begin : g_rest
            assign take_new[i]   = gt[i] && !gt[i-1];
            assign prev_dist[i]  = slot_dist_q[i-1];
            assign prev_label[i] = slot_label_q[i-1];
            assign prev_vld[i]   = slot_vld_q[i-1];
        end
        assign take_prev[i] = gt[i] && !take_new[i];

        assign slot_vld_d[i]   = start_acc     ? 1'b0 :
                                 !vld_p1       ? slot_vld_q[i] :
                                 take_new[i]   ? 1'b1 :
                                 take_prev[i]  ? prev_vld[i] : slot_vld_q[i];
        assign slot_dist_d[i]  = (!vld_p1 || start_acc) ? slot_dist_q[i] :
                                 take_new[i]   ? dist_p1 :
                                 take_prev[i]  ? prev_dist[i] : slot_dist_q[i];
        assign slot_label_d[i] = (!vld_p1 || start_acc) ? slot_label_q[i] :
                                 take_new[i]   ? label_p1 :
                                 take_prev[i]  ? prev_label[i] : slot_label_q[i];

        assign nbr_dist [i*DIST_W  +: DIST_W]  = slot_dist_q[i];
        assign nbr_label[i*LABEL_W +: LABEL_W] = slot_label_q[i];
        assign nbr_valid[i]                    = slot_vld_q[i];
    end

    // ---- stage 1 -> stage 2 boundary ----
    // Controller, test point and sorted list; reset empties everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            test_x_q <= '0;
            test_y_q <= '0;
            for (int i = 0; i < K; i++) begin
                slot_dist_q[i]  <= '0;
                slot_label_q[i] <= '0;
                slot_vld_q[i]   <= 1'b0;
            end
        end else begin
            state_q  <= state_d;
            test_x_q <= test_x_d;
            test_y_q <= test_y_d;
            for (int i = 0; i < K; i++) begin
                slot_dist_q[i]  <= slot_dist_d[i];
                slot_label_q[i] <= slot_label_d[i];
                slot_vld_q[i]   <= slot_vld_d[i];
            end
        end
    end

endmodule
